// File: rtl/memory_pkg.sv
// ============================================================================
// Module   : memory_pkg
// Brief    : Shared state encoding and default parameters for dual_port_memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package memory_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int C_DATA_W      = 12;
    localparam int C_ADDR_W      = 12;
    localparam int C_SIZE        = 1337;
    localparam int C_WRITE_FIRST = 0;
    localparam int C_CLEAR_VALUE = 0;

    // Index width that spans 0..size-1, never narrower than one bit.
    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_clear_ctrl.sv
// ============================================================================
// Module   : memory_clear_ctrl
// Brief    : Post-reset clear sequencer; sweeps every word address once.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_clear_ctrl
    import memory_pkg::*;
#(
    parameter int SIZE  = C_SIZE,
    parameter int IDX_W = idx_width(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_clear_addr,
    output logic             o_clear_we
);

    localparam logic [IDX_W-1:0] C_LAST_ADDR = IDX_W'(SIZE - 1);

    state_t           r_state_q;
    state_t           w_state_d;
    logic [IDX_W-1:0] r_count_q;
    logic [IDX_W-1:0] w_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= CLEAR;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_count_d  = r_count_q;
        o_clear_we = 1'b0;
        case (r_state_q)
            CLEAR: begin
                o_clear_we = 1'b1;
                // Leave on the same edge that writes the final address.
                if (r_count_q == C_LAST_ADDR) begin
                    w_state_d = READY;
                    w_count_d = '0;
                end else begin
                    w_count_d = r_count_q + IDX_W'(1);
                end
            end
            READY: begin
                w_state_d = READY;
            end
            default: begin
                w_state_d = CLEAR;
                w_count_d = '0;
            end
        endcase
    end

    assign o_busy       = (r_state_q == CLEAR);
    assign o_clear_addr = r_count_q;

endmodule

`default_nettype wire

// File: rtl/dual_port_memory.sv
// ============================================================================
// Module   : dual_port_memory
// Brief    : Single-clock 1W/1R memory with self-clear, range checking and
//            configurable read-during-write behaviour.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dual_port_memory
    import memory_pkg::*;
#(
    parameter int                DATA_W      = C_DATA_W,
    parameter int                ADDR_W      = C_ADDR_W,
    parameter int                SIZE        = C_SIZE,
    parameter int                WRITE_FIRST = C_WRITE_FIRST,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(C_CLEAR_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              wr_err,
    output logic              rd_err,
    output logic              busy
);

    localparam int                IDX_W      = idx_width(SIZE);
    localparam logic [ADDR_W:0]   C_SIZE_EXT = (ADDR_W + 1)'(SIZE);

    logic [DATA_W-1:0] r_mem [SIZE];

    logic              w_busy;
    logic              w_clear_we;
    logic [IDX_W-1:0]  w_clear_addr;

    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_collision;

    logic [DATA_W-1:0] r_data_out_q;
    logic [DATA_W-1:0] w_data_out_d;
    logic              r_data_valid_q;
    logic              w_data_valid_d;
    logic              r_wr_err_q;
    logic              w_wr_err_d;
    logic              r_rd_err_q;
    logic              w_rd_err_d;

    memory_clear_ctrl #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_clear_ctrl (
        .clk          (clk),
        .rst          (rst),
        .o_busy       (w_busy),
        .o_clear_addr (w_clear_addr),
        .o_clear_we   (w_clear_we)
    );

    // Requests are dropped entirely while the clear sweep owns the array.
    assign w_wr_req      = write_enable & ~w_busy;
    assign w_rd_req      = read_enable & ~w_busy;
    assign w_wr_in_range = ({1'b0, wr_addr} < C_SIZE_EXT);
    assign w_rd_in_range = ({1'b0, rd_addr} < C_SIZE_EXT);
    assign w_wr_idx      = wr_addr[IDX_W-1:0];
    assign w_rd_idx      = rd_addr[IDX_W-1:0];
    assign w_collision   = w_wr_req & w_wr_in_range & (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clear_we) begin
                r_mem[w_clear_addr] <= CLEAR_VALUE;
            end else if (w_wr_req && w_wr_in_range) begin
                r_mem[w_wr_idx] <= data_in;
            end
        end
    end

    always_comb begin
        w_data_out_d   = r_data_out_q;
        w_data_valid_d = 1'b0;
        w_rd_err_d     = 1'b0;
        w_wr_err_d     = w_wr_req & ~w_wr_in_range;
        if (w_rd_req) begin
            w_data_valid_d = 1'b1;
            if (!w_rd_in_range) begin
                w_data_out_d = '0;
                w_rd_err_d   = 1'b1;
            end else if ((WRITE_FIRST != 0) && w_collision) begin
                w_data_out_d = data_in;
            end else begin
                w_data_out_d = r_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out_q   <= '0;
            r_data_valid_q <= 1'b0;
            r_wr_err_q     <= 1'b0;
            r_rd_err_q     <= 1'b0;
        end else begin
            r_data_out_q   <= w_data_out_d;
            r_data_valid_q <= w_data_valid_d;
            r_wr_err_q     <= w_wr_err_d;
            r_rd_err_q     <= w_rd_err_d;
        end
    end

    assign data_out   = r_data_out_q;
    assign data_valid = r_data_valid_q;
    assign wr_err     = r_wr_err_q;
    assign rd_err     = r_rd_err_q;
    assign busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_memory.sv
// ============================================================================
// Module   : tb_dual_port_memory
// Brief    : Self-checking bench; read-first and write-first instances share
//            stimulus and are compared against a behavioural memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dual_port_memory;

    localparam int C_SZ = 1337;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic        re  = 1'b0;
    logic [11:0] wa  = '0;
    logic [11:0] din = '0;
    logic [11:0] ra  = '0;

    logic [11:0] dout0, dout1;
    logic        v0, v1, wer0, wer1, rer0, rer1, b0, b1;

    int checks   = 0;
    int failures = 0;

    dual_port_memory #(.DATA_W(12), .ADDR_W(12), .SIZE(C_SZ), .WRITE_FIRST(0), .CLEAR_VALUE(12'h000)) u_dut_rf (
        .clk(clk), .rst(rst), .write_enable(we), .wr_addr(wa), .data_in(din),
        .read_enable(re), .rd_addr(ra), .data_out(dout0), .data_valid(v0),
        .wr_err(wer0), .rd_err(rer0), .busy(b0)
    );

    dual_port_memory #(.DATA_W(12), .ADDR_W(12), .SIZE(C_SZ), .WRITE_FIRST(1), .CLEAR_VALUE(12'h000)) u_dut_wf (
        .clk(clk), .rst(rst), .write_enable(we), .wr_addr(wa), .data_in(din),
        .read_enable(re), .rd_addr(ra), .data_out(dout1), .data_valid(v1),
        .wr_err(wer1), .rd_err(rer1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array plus a count of remaining clear cycles.
    logic [11:0] mm [C_SZ];
    int          remaining = 0;
    bit          started   = 0;
    logic [11:0] e_dout_rf = '0;
    logic [11:0] e_dout_wf = '0;
    logic        e_valid = 0, e_wr = 0, e_rd = 0, e_busy = 1;

    always @(posedge clk) begin
        if (rst) begin
            started   = 1;
            remaining = C_SZ;
            e_valid   = 0; e_wr = 0; e_rd = 0;
            e_dout_rf = '0; e_dout_wf = '0;
        end else if (remaining > 0) begin
            mm[C_SZ - remaining] = 12'h000;
            remaining--;
            e_valid = 0; e_wr = 0; e_rd = 0;
        end else begin
            e_valid = 0; e_wr = 0; e_rd = 0;
            if (re) begin
                e_valid = 1;
                if (int'(ra) < C_SZ) begin
                    e_dout_rf = mm[ra];
                    e_dout_wf = (we && int'(wa) < C_SZ && wa == ra) ? din : mm[ra];
                end else begin
                    e_rd = 1; e_dout_rf = '0; e_dout_wf = '0;
                end
            end
            if (we) begin
                if (int'(wa) < C_SZ) mm[wa] = din;
                else e_wr = 1;
            end
        end
        e_busy = (remaining > 0);
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            check("busy_rf", b0, e_busy);     check("busy_wf", b1, e_busy);
            check("valid_rf", v0, e_valid);   check("valid_wf", v1, e_valid);
            check("wr_err_rf", wer0, e_wr);   check("wr_err_wf", wer1, e_wr);
            check("rd_err_rf", rer0, e_rd);   check("rd_err_wf", rer1, e_rd);
            check("dout_rf", dout0, e_dout_rf);
            check("dout_wf", dout1, e_dout_wf);
        end
    end

    task automatic drive(input logic w, input logic [11:0] a, input logic [11:0] d,
                         input logic r, input logic [11:0] b);
        @(negedge clk);
        we = w; wa = a; din = d; re = r; ra = b;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (b0 === 1'b1 && n < 4000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", b0, 1'b1);
        check("rst_valid", v0, 1'b0);
        check("rst_dout", dout0, 12'h000);
        check("rst_errs", {wer0, rer0}, 2'b00);

        // Requests held through the whole clear must have no effect.
        @(negedge clk);
        rst = 1'b0; we = 1'b1; wa = 12'd0; din = 12'h555; re = 1'b1; ra = 12'd3;
        count_busy(n);
        we = 1'b0; re = 1'b0;
        check("busy_len_first", n, 1337);

        drive(0, 0, 0, 1, 12'd1336);
        check("rd_last_dout", dout0, 12'h000);
        check("rd_last_valid", v0, 1'b1);
        drive(0, 0, 0, 1, 12'd0);
        check("rd_0_after_busy_we", dout0, 12'h000);

        drive(1, 12'd5, 12'hABC, 0, 0);
        drive(0, 0, 0, 1, 12'd5);
        check("rd5_dout", dout0, 12'hABC);
        check("rd5_valid", v0, 1'b1);
        check("rd5_err", rer0, 1'b0);

        drive(1, 12'd1337, 12'h777, 1, 12'd4095);
        check("oor_wr_err", wer0, 1'b1);
        check("oor_rd_err", rer0, 1'b1);
        check("oor_dout", dout0, 12'h000);
        drive(0, 0, 0, 0, 0);
        check("oor_wr_err_clears", wer0, 1'b0);
        drive(0, 0, 0, 1, 12'd0);
        check("oor_addr0_intact", dout0, 12'h000);

        drive(1, 12'd7, 12'h111, 0, 0);
        drive(1, 12'd7, 12'h222, 1, 12'd7);
        check("coll_read_first", dout0, 12'h111);
        check("coll_write_first", dout1, 12'h222);
        drive(0, 0, 0, 1, 12'd7);
        check("coll_after_rf", dout0, 12'h222);
        check("coll_after_wf", dout1, 12'h222);

        drive(1, 12'd8, 12'h333, 1, 12'd5);
        check("indep_rd5", dout0, 12'hABC);
        drive(0, 0, 0, 0, 0);
        check("hold_dout", dout0, 12'hABC);
        check("hold_valid", v0, 1'b0);
        drive(0, 0, 0, 1, 12'd8);
        check("indep_rd8", dout0, 12'h333);

        // Abort the clear when it reaches address 600, then expect a full restart.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("busy_len_restart", n, 1337);
        drive(0, 0, 0, 1, 12'd5);
        check("cleared_rd5", dout0, 12'h000);
        drive(0, 0, 0, 1, 12'd8);
        check("cleared_rd8", dout0, 12'h000);

        for (int a = 0; a < C_SZ; a++) drive(1, 12'(a), 12'(a), 0, 0);
        for (int a = 0; a < C_SZ; a++) begin
            drive(0, 0, 0, 1, 12'(a));
            check("sweep_rd", dout0, 12'(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 12, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, address width in bits.
REQ-003 SHALL have parameter SIZE, default 1337, number of words; 1 <= SIZE <= 2**ADDR_W.
REQ-004 SHALL have parameter WRITE_FIRST, default 0, collision mode: 1 = new data, 0 = old data.
REQ-005 SHALL have parameter CLEAR_VALUE, default 0, DATA_W-bit word written to every address during clear.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port write_enable  input  1  write request this cycle.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port data_in  input  DATA_W  write data.
REQ-011 SHALL have port read_enable  input  1  read request this cycle.
REQ-012 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-013 SHALL have port data_out  output  DATA_W  registered read data.
REQ-014 SHALL have port data_valid  output  1  data_out updated by the previous cycle's read.
REQ-015 SHALL have port wr_err  output  1  previous cycle's write was out of range.
REQ-016 SHALL have port rd_err  output  1  previous cycle's read was out of range.
REQ-017 SHALL have port busy  output  1  clear in progress; requests are ignored.

Function
REQ-018 SHALL implement FSM states CLEAR and READY.
REQ-019 SHALL, in CLEAR, write CLEAR_VALUE to one address per cycle, clear counter 0 to SIZE-1, starting on the first edge with rst=0.
REQ-020 SHALL go CLEAR->READY on the edge that writes address SIZE-1, so busy=1 for exactly SIZE cycles after rst deasserts.
REQ-021 SHALL drop write_enable and read_enable while busy=1: no write, data_valid=0, no errors.
REQ-022 SHALL, in READY with write_enable=1 and wr_addr<SIZE, store data_in at mem[wr_addr] on that edge.
REQ-023 SHALL, on a write with wr_addr>=SIZE, leave memory unchanged and assert wr_err for exactly one cycle after the edge.
REQ-024 SHALL, in READY with read_enable=1 and rd_addr<SIZE, present mem[rd_addr] on data_out one cycle later (latency 1), with data_valid=1 for that one cycle.
REQ-025 SHALL, on a read with rd_addr>=SIZE, set data_out=0, data_valid=1 and rd_err=1 for one cycle.
REQ-026 SHALL hold data_out unchanged when no read is accepted; data_valid=0 in that case.
REQ-027 SHALL resolve a same-cycle write and read to the same in-range address per WRITE_FIRST: 1 -> data_out=data_in; 0 -> data_out=prior content; memory is updated in both modes.
REQ-028 SHALL handle simultaneous in-range reads and writes to different addresses fully independently.
REQ-029 SHALL, if rst is asserted mid-clear or mid-access, abort the operation and restart the clear from address 0 after rst deasserts.

Reset
REQ-030 SHALL, on a clock edge with rst=1, set data_out=0, data_valid=0, wr_err=0, rd_err=0, busy=1, state=CLEAR, clear counter=0.
REQ-031 SHALL not write the memory array while rst=1.

Structure
REQ-032 SHALL take the state enum typedef (CLEAR, READY) and default parameter constants from shared package memory_pkg.
REQ-033 SHALL place the FSM and clear counter in sub-module memory_clear_ctrl, which outputs busy, clear address and clear write strobe.
REQ-034 SHALL keep the storage array and read/write ports in dual_port_memory itself.

Verification (DATA_W=12, ADDR_W=12, SIZE=1337 unless stated)
REQ-035 SHALL cover: rst high for 3 cycles, then low -> busy=1 for exactly 1337 cycles; a read of address 1336 after busy falls returns 0 with data_valid=1.
REQ-036 SHALL cover: write 0xABC to address 5, then read address 5 -> data_out=0xABC and data_valid=1 one cycle after the read request, rd_err=0.
REQ-037 SHALL cover: write to address 1337 and read address 4095 -> wr_err=1 for one cycle; data_out=0 with rd_err=1; address 1337 mod SIZE (=0) is not modified.
REQ-038 SHALL cover: address 7 holds 0x111; same-cycle write 0x222 and read of address 7 -> data_out=0x111 (WRITE_FIRST=0) or 0x222 (WRITE_FIRST=1); a following read returns 0x222 in both modes.
REQ-039 SHALL cover: write_enable held with data 0x555 during busy -> no memory change; assert rst at clear address 600 -> busy restarts and lasts 1337 cycles.
REQ-040 SHALL cover: sweep all addresses 0..1336, writing value=address and reading back -> every read matches, no errors flagged.
